// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the ID-stage hazard controller and the pipeline datapath.
// The datapath side (master) supplies decoded fields; the controller side (slave) returns enables.
interface hazard_ctrl_if #(
    parameter int CNT_WIDTH = 32
);
    logic [4:0]           id_addrRs;
    logic [4:0]           id_addrRt;
    logic                 id_useRs;
    logic                 id_useRt;
    logic                 ex_memRead;
    logic [4:0]           ex_addrRd;
    logic                 ex_muldiv;
    logic                 branch_taken;
    logic                 perf_clear;
    logic                 pc_write;
    logic                 ifid_write;
    logic                 ifid_flush;
    logic                 idex_write;
    logic                 idex_bubble;
    logic                 exmem_bubble;
    logic                 muldiv_start;
    logic [CNT_WIDTH-1:0] stall_cycles;

    modport master (
        output id_addrRs, id_addrRt, id_useRs, id_useRt,
        output ex_memRead, ex_addrRd, ex_muldiv, branch_taken, perf_clear,
        input  pc_write, ifid_write, ifid_flush, idex_write,
        input  idex_bubble, exmem_bubble, muldiv_start, stall_cycles
    );

    modport slave (
        input  id_addrRs, id_addrRt, id_useRs, id_useRt,
        input  ex_memRead, ex_addrRd, ex_muldiv, branch_taken, perf_clear,
        output pc_write, ifid_write, ifid_flush, idex_write,
        output idex_bubble, exmem_bubble, muldiv_start, stall_cycles
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and mul/div EX occupancy,
// plus a saturating count of cycles in which the PC was held.
module hazard_ctrl #(
    parameter int MULDIV_CYCLES = 32,
    parameter int CNT_WIDTH     = 32
) (
    input  logic          clock,
    input  logic          reset,
    hazard_ctrl_if.slave  hz
);
    localparam int CW = $clog2(MULDIV_CYCLES);
    localparam logic [CW-1:0] CNT_INIT = CW'(MULDIV_CYCLES - 2);

    typedef enum logic {
        RUN,
        MD_WAIT
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] stall_q, stall_d;

    logic loadUse;
    logic pcWrite, ifidWrite, ifidFlush, idexWrite, idexBubble, exmemBubble, muldivStart;

    // A write to $0 is discarded by the register file, so it can never create a dependency.
    assign loadUse = hz.ex_memRead && (hz.ex_addrRd != 5'd0) &&
                     ((hz.id_useRs && (hz.ex_addrRd == hz.id_addrRs)) ||
                      (hz.id_useRt && (hz.ex_addrRd == hz.id_addrRt)));

    always_comb begin
        pcWrite     = 1'b1;
        ifidWrite   = 1'b1;
        ifidFlush   = 1'b0;
        idexWrite   = 1'b1;
        idexBubble  = 1'b0;
        exmemBubble = 1'b0;
        muldivStart = 1'b0;
        state_d     = state_q;
        cnt_d       = cnt_q;

        case (state_q)
            RUN: begin
                if (hz.ex_muldiv) begin
                    pcWrite     = 1'b0;
                    ifidWrite   = 1'b0;
                    idexWrite   = 1'b0;
                    exmemBubble = 1'b1;
                    muldivStart = 1'b1;
                    state_d     = MD_WAIT;
                    cnt_d       = CNT_INIT;
                end else if (hz.branch_taken) begin
                    ifidFlush  = 1'b1;
                    idexBubble = 1'b1;
                end else if (loadUse) begin
                    pcWrite    = 1'b0;
                    ifidWrite  = 1'b0;
                    idexBubble = 1'b1;
                end
            end
            MD_WAIT: begin
                if (cnt_q != '0) begin
                    pcWrite     = 1'b0;
                    ifidWrite   = 1'b0;
                    idexWrite   = 1'b0;
                    exmemBubble = 1'b1;
                    cnt_d       = cnt_q - CW'(1);
                end else begin
                    // Release cycle: EX/MEM takes the result while ID may still face a load-use stall.
                    if (loadUse) begin
                        pcWrite    = 1'b0;
                        ifidWrite  = 1'b0;
                        idexBubble = 1'b1;
                    end
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase

        if (!reset) begin
            pcWrite     = 1'b1;
            ifidWrite   = 1'b1;
            ifidFlush   = 1'b0;
            idexWrite   = 1'b1;
            idexBubble  = 1'b0;
            exmemBubble = 1'b0;
            muldivStart = 1'b0;
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (hz.perf_clear) begin
            stall_d = '0;
        end else if (!pcWrite && (stall_q != '1)) begin
            stall_d = stall_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end

    assign hz.pc_write     = pcWrite;
    assign hz.ifid_write   = ifidWrite;
    assign hz.ifid_flush   = ifidFlush;
    assign hz.idex_write   = idexWrite;
    assign hz.idex_bubble  = idexBubble;
    assign hz.exmem_bubble = exmemBubble;
    assign hz.muldiv_start = muldivStart;
    assign hz.stall_cycles = stall_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed corner cases followed by random traffic,
// compared against a cycle-level model tracking remaining EX occupancy and an integer stall count.
module tb_hazard_ctrl;
    localparam int MD_CYC = 4;
    localparam int CNT_W  = 5;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    // Control vector order: pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_bubble, muldiv_start
    localparam logic [6:0] CTL_RUN   = 7'b1101000;
    localparam logic [6:0] CTL_MDGO  = 7'b0000011;
    localparam logic [6:0] CTL_MDHLD = 7'b0000010;
    localparam logic [6:0] CTL_BR    = 7'b1111100;
    localparam logic [6:0] CTL_LU    = 7'b0001100;

    logic clock;
    logic reset;

    int checksRun    = 0;
    int checksPassed = 0;
    int mdLeft       = 0;
    int expStall     = 0;

    hazard_ctrl_if #(.CNT_WIDTH(CNT_W)) hz ();

    hazard_ctrl #(
        .MULDIV_CYCLES(MD_CYC),
        .CNT_WIDTH    (CNT_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .hz   (hz.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checksRun++;
        if (observed === expected) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [6:0] observedCtl();
        return {hz.pc_write, hz.ifid_write, hz.ifid_flush, hz.idex_write,
                hz.idex_bubble, hz.exmem_bubble, hz.muldiv_start};
    endfunction

    // Called just after a falling edge: drive one cycle, check mid-cycle, advance model at the rising edge.
    task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt, input logic useRs,
                                 input logic useRt, input logic memRead, input logic [4:0] rd,
                                 input logic muldiv, input logic branch, input logic clear);
        logic       lu;
        logic [6:0] expCtl;
        int         nextMd;
        hz.id_addrRs    = rs;
        hz.id_addrRt    = rt;
        hz.id_useRs     = useRs;
        hz.id_useRt     = useRt;
        hz.ex_memRead   = memRead;
        hz.ex_addrRd    = rd;
        hz.ex_muldiv    = muldiv;
        hz.branch_taken = branch;
        hz.perf_clear   = clear;
        #1;
        lu = memRead && (rd != 0) && ((useRs && rd == rs) || (useRt && rd == rt));
        nextMd = 0;
        if (mdLeft > 1) begin
            expCtl = CTL_MDHLD;
            nextMd = mdLeft - 1;
        end else if (mdLeft == 1) begin
            expCtl = lu ? CTL_LU : CTL_RUN;
        end else if (muldiv) begin
            expCtl = CTL_MDGO;
            nextMd = MD_CYC - 1;
        end else if (branch) begin
            expCtl = CTL_BR;
        end else if (lu) begin
            expCtl = CTL_LU;
        end else begin
            expCtl = CTL_RUN;
        end
        checkOutput("ctl", 32'(observedCtl()), 32'(expCtl));
        checkOutput("stall_cycles", 32'(hz.stall_cycles), 32'(expStall));
        @(posedge clock);
        if (clear) expStall = 0;
        else if (!expCtl[6] && expStall < CNT_MAX) expStall++;
        mdLeft = nextMd;
        @(negedge clock);
    endtask

    task automatic idle();
        applyStimulus(5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Pulses reset in the middle of a cycle, leaving inputs as they are.
    task automatic midReset();
        #2;
        reset = 1'b0;
        #1;
        checkOutput("reset_ctl", 32'(observedCtl()), 32'(CTL_RUN));
        checkOutput("reset_stall", 32'(hz.stall_cycles), 32'd0);
        mdLeft   = 0;
        expStall = 0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        hz.id_addrRs = 5'd3; hz.id_addrRt = 5'd3; hz.id_useRs = 1'b1; hz.id_useRt = 1'b1;
        hz.ex_memRead = 1'b1; hz.ex_addrRd = 5'd3; hz.ex_muldiv = 1'b1;
        hz.branch_taken = 1'b1; hz.perf_clear = 1'b0;
        #3;
        checkOutput("por_ctl", 32'(observedCtl()), 32'(CTL_RUN));
        checkOutput("por_stall", 32'(hz.stall_cycles), 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;

        // Load-use on Rs, then idle to observe the count
        applyStimulus(5'd5, 5'd7, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        idle();
        // Load into $0 never stalls; load-use on Rt; Rt match but Rt unused
        applyStimulus(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(5'd1, 5'd9, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
        applyStimulus(5'd1, 5'd9, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
        // Taken branch overrides load-use
        applyStimulus(5'd5, 5'd7, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0);
        idle();
        // mul/div held across its whole occupancy, then back-to-back, then released
        for (int i = 0; i < 2 * MD_CYC; i++)
            applyStimulus(5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0);
        idle();
        // Release cycle sees a load-use
        applyStimulus(5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < MD_CYC - 2; i++)
            applyStimulus(5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
        applyStimulus(5'd6, 5'd2, 1'b1, 1'b0, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        idle();
        // Reset while in MD_WAIT with one hold cycle remaining
        applyStimulus(5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
        applyStimulus(5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
        midReset();
        idle();
        // Drive the counter into saturation, hold there, then clear during a stall
        for (int i = 0; i < 12 * MD_CYC; i++)
            applyStimulus(5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
        checkOutput("saturated", 32'(hz.stall_cycles), 32'(CNT_MAX));
        applyStimulus(5'd5, 5'd7, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        applyStimulus(5'd5, 5'd7, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1);
        idle();

        // Random traffic with small register numbers so hazards are frequent
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                midReset();
            end else begin
                applyStimulus(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                              ($urandom_range(0, 7) == 0), ($urandom_range(0, 4) == 0),
                              ($urandom_range(0, 39) == 0));
            end
        end

        $display("%0d/%0d checks passed", checksPassed, checksRun);
        $finish;
    end
endmodule
